// File: rtl/conv_layer_sequencer_if.sv
// Control bus between the layer sequencer and the conv/pool/FC/loader engines.
// The sequencer owns the layer state; engines return done strobes and the conv write address.
`timescale 1ns/1ps
interface conv_layer_sequencer_if #(
  parameter int STATE_DATAWIDTH   = 4,
  parameter int ADDRESS_DATAWIDTH = 13,
  parameter int LOOP_DATAWIDTH    = 3,
  parameter int FILTER_DATAWIDTH  = 5
);
  logic                         start;
  logic                         aux_done;
  logic                         addr_valid;
  logic [ADDRESS_DATAWIDTH-1:0] Out_Address;
  logic [STATE_DATAWIDTH-1:0]   state;
  logic [LOOP_DATAWIDTH-1:0]    current_loop;
  logic [FILTER_DATAWIDTH-1:0]  current_filter;
  logic                         last_loop;
  logic                         pass_start;
  logic                         layer_done;
  logic                         frame_done;

  modport master (
    input  start, aux_done, addr_valid, Out_Address,
    output state, current_loop, current_filter, last_loop, pass_start, layer_done, frame_done
  );

  modport slave (
    output start, aux_done, addr_valid, Out_Address,
    input  state, current_loop, current_filter, last_loop, pass_start, layer_done, frame_done
  );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Layer scheduler for the CNN accelerator: walks LOAD -> CONV/POOL blocks -> FC,
// counting input-channel passes and output filters inside each convolution layer.
`timescale 1ns/1ps
module conv_layer_sequencer #(
  parameter int STATE_DATAWIDTH     = 4,
  parameter int ADDRESS_DATAWIDTH   = 13,
  parameter int LOOP_DATAWIDTH      = 3,
  parameter int FILTER_DATAWIDTH    = 5,
  parameter int CONV1_1_OUTPUT_SIZE = 82,
  parameter int CONV1_2_OUTPUT_SIZE = 80,
  parameter int CONV2_1_OUTPUT_SIZE = 38,
  parameter int CONV2_2_OUTPUT_SIZE = 36,
  parameter int CONV3_1_OUTPUT_SIZE = 16,
  parameter int CONV3_2_OUTPUT_SIZE = 14,
  parameter int CONV1_1_LOOPS       = 1,
  parameter int CONV1_2_LOOPS       = 2,
  parameter int CONV2_1_LOOPS       = 2,
  parameter int CONV2_2_LOOPS       = 4,
  parameter int CONV3_1_LOOPS       = 4,
  parameter int CONV3_2_LOOPS       = 4,
  parameter int CONV1_FILTERS       = 6,
  parameter int CONV2_FILTERS       = 16,
  parameter int CONV3_FILTERS       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  conv_layer_sequencer_if.master bus
);

  localparam int C11_LAST = CONV1_1_OUTPUT_SIZE * CONV1_1_OUTPUT_SIZE - 1;
  localparam int C12_LAST = CONV1_2_OUTPUT_SIZE * CONV1_2_OUTPUT_SIZE - 1;
  localparam int C21_LAST = CONV2_1_OUTPUT_SIZE * CONV2_1_OUTPUT_SIZE - 1;
  localparam int C22_LAST = CONV2_2_OUTPUT_SIZE * CONV2_2_OUTPUT_SIZE - 1;
  localparam int C31_LAST = CONV3_1_OUTPUT_SIZE * CONV3_1_OUTPUT_SIZE - 1;
  localparam int C32_LAST = CONV3_2_OUTPUT_SIZE * CONV3_2_OUTPUT_SIZE - 1;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,  S_LOAD    = 4'd1,  S_CONV1_1 = 4'd2,  S_CONV1_2 = 4'd3,
    S_POOL1   = 4'd4,  S_CONV2_1 = 4'd5,  S_CONV2_2 = 4'd6,  S_POOL2   = 4'd7,
    S_CONV3_1 = 4'd8,  S_CONV3_2 = 4'd9,  S_POOL3   = 4'd10, S_FC      = 4'd11
  } state_t;

  state_t                       r_state, w_state_nxt, w_succ;
  logic [LOOP_DATAWIDTH-1:0]    r_loop, w_loop_nxt, w_loops_m1;
  logic [FILTER_DATAWIDTH-1:0]  r_filter, w_filter_nxt, w_filters_m1;
  logic [ADDRESS_DATAWIDTH-1:0] w_last;
  logic                         r_pass_start, r_layer_done, r_frame_done;
  logic                         w_pass_nxt, w_layer_nxt, w_frame_nxt;
  logic                         w_is_conv, w_pass_end, w_last_loop, w_last_filter;
  logic                         w_conv_end, w_done, w_layer;

  function automatic logic f_is_conv(input state_t s);
    return (s == S_CONV1_1) || (s == S_CONV1_2) || (s == S_CONV2_1) ||
           (s == S_CONV2_2) || (s == S_CONV3_1) || (s == S_CONV3_2);
  endfunction

  // Per-layer geometry: final write address, last loop index, last filter index
  always_comb begin
    w_is_conv    = 1'b1;
    w_last       = '0;
    w_loops_m1   = '0;
    w_filters_m1 = '0;
    case (r_state)
      S_CONV1_1: begin
        w_last = ADDRESS_DATAWIDTH'(C11_LAST); w_loops_m1 = LOOP_DATAWIDTH'(CONV1_1_LOOPS - 1);
        w_filters_m1 = FILTER_DATAWIDTH'(CONV1_FILTERS - 1);
      end
      S_CONV1_2: begin
        w_last = ADDRESS_DATAWIDTH'(C12_LAST); w_loops_m1 = LOOP_DATAWIDTH'(CONV1_2_LOOPS - 1);
        w_filters_m1 = FILTER_DATAWIDTH'(CONV1_FILTERS - 1);
      end
      S_CONV2_1: begin
        w_last = ADDRESS_DATAWIDTH'(C21_LAST); w_loops_m1 = LOOP_DATAWIDTH'(CONV2_1_LOOPS - 1);
        w_filters_m1 = FILTER_DATAWIDTH'(CONV2_FILTERS - 1);
      end
      S_CONV2_2: begin
        w_last = ADDRESS_DATAWIDTH'(C22_LAST); w_loops_m1 = LOOP_DATAWIDTH'(CONV2_2_LOOPS - 1);
        w_filters_m1 = FILTER_DATAWIDTH'(CONV2_FILTERS - 1);
      end
      S_CONV3_1: begin
        w_last = ADDRESS_DATAWIDTH'(C31_LAST); w_loops_m1 = LOOP_DATAWIDTH'(CONV3_1_LOOPS - 1);
        w_filters_m1 = FILTER_DATAWIDTH'(CONV3_FILTERS - 1);
      end
      S_CONV3_2: begin
        w_last = ADDRESS_DATAWIDTH'(C32_LAST); w_loops_m1 = LOOP_DATAWIDTH'(CONV3_2_LOOPS - 1);
        w_filters_m1 = FILTER_DATAWIDTH'(CONV3_FILTERS - 1);
      end
      default: w_is_conv = 1'b0;
    endcase
  end

  assign w_pass_end    = w_is_conv && bus.addr_valid && (bus.Out_Address == w_last);
  assign w_last_loop   = w_is_conv && (r_loop == w_loops_m1);
  assign w_last_filter = (r_filter == w_filters_m1);
  assign w_conv_end    = w_pass_end && w_last_loop && w_last_filter;

  // Successor state and the event that completes the current state
  always_comb begin
    w_succ  = S_IDLE;
    w_done  = 1'b0;
    w_layer = 1'b1;
    case (r_state)
      S_IDLE:    begin w_succ = S_LOAD;    w_done = bus.start; w_layer = 1'b0; end
      S_LOAD:    begin w_succ = S_CONV1_1; w_done = bus.aux_done; end
      S_CONV1_1: begin w_succ = S_CONV1_2; w_done = w_conv_end;   end
      S_CONV1_2: begin w_succ = S_POOL1;   w_done = w_conv_end;   end
      S_POOL1:   begin w_succ = S_CONV2_1; w_done = bus.aux_done; end
      S_CONV2_1: begin w_succ = S_CONV2_2; w_done = w_conv_end;   end
      S_CONV2_2: begin w_succ = S_POOL2;   w_done = w_conv_end;   end
      S_POOL2:   begin w_succ = S_CONV3_1; w_done = bus.aux_done; end
      S_CONV3_1: begin w_succ = S_CONV3_2; w_done = w_conv_end;   end
      S_CONV3_2: begin w_succ = S_POOL3;   w_done = w_conv_end;   end
      S_POOL3:   begin w_succ = S_FC;      w_done = bus.aux_done; end
      S_FC:      begin w_succ = S_IDLE;    w_done = bus.aux_done; end
      default:   begin w_succ = S_IDLE;    w_done = 1'b1; w_layer = 1'b0; end
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_loop_nxt   = r_loop;
    w_filter_nxt = r_filter;
    w_pass_nxt   = 1'b0;
    w_layer_nxt  = 1'b0;
    w_frame_nxt  = 1'b0;
    if (w_done) begin
      w_state_nxt  = w_succ;
      w_loop_nxt   = '0;
      w_filter_nxt = '0;
      w_pass_nxt   = f_is_conv(w_succ);
      w_layer_nxt  = w_layer;
      w_frame_nxt  = (r_state == S_FC);
    end else if (w_pass_end) begin
      w_pass_nxt = 1'b1;
      if (w_last_loop) begin
        w_loop_nxt   = '0;
        w_filter_nxt = r_filter + 1'b1;
      end else begin
        w_loop_nxt = r_loop + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_loop       <= '0;
      r_filter     <= '0;
      r_pass_start <= 1'b0;
      r_layer_done <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_loop       <= w_loop_nxt;
      r_filter     <= w_filter_nxt;
      r_pass_start <= w_pass_nxt;
      r_layer_done <= w_layer_nxt;
      r_frame_done <= w_frame_nxt;
    end
  end

  assign bus.state          = STATE_DATAWIDTH'(r_state);
  assign bus.current_loop   = r_loop;
  assign bus.current_filter = r_filter;
  assign bus.last_loop      = w_last_loop;
  assign bus.pass_start     = r_pass_start;
  assign bus.layer_done     = r_layer_done;
  assign bus.frame_done     = r_frame_done;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: reset, per-layer pass counting,
// distractor rejection, full-frame state walk and reset in the middle of a layer.
`timescale 1ns/1ps
module tb_conv_layer_sequencer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   n_layer_pulses;
  int   n_frame_pulses;
  logic mon_en;
  logic [3:0] seq_q[$];
  logic [3:0] prev_state;

  conv_layer_sequencer_if bus ();

  conv_layer_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame monitor: records each distinct state and counts done pulses
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.state !== prev_state) begin
        seq_q.push_back(bus.state);
        prev_state = bus.state;
      end
      if (bus.layer_done === 1'b1) n_layer_pulses++;
      if (bus.frame_done === 1'b1) n_frame_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_passes(input int n, input int addr);
    for (int i = 0; i < n; i++) begin
      bus.addr_valid  = 1'b1;
      bus.Out_Address = 13'(addr);
      tick();
    end
    bus.addr_valid = 1'b0;
  endtask

  task automatic aux_pulse();
    bus.aux_done = 1'b1;
    tick();
    bus.aux_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.state !== 4'd0) begin n_err++; $display("FAIL rst_state got=%0d exp=0", bus.state); end
    n_cmp++; if (bus.current_loop !== 3'd0) begin n_err++; $display("FAIL rst_loop got=%0d exp=0", bus.current_loop); end
    n_cmp++; if (bus.current_filter !== 5'd0) begin n_err++; $display("FAIL rst_filter got=%0d exp=0", bus.current_filter); end
    n_cmp++; if (bus.pass_start !== 1'b0) begin n_err++; $display("FAIL rst_pass_start got=%0b exp=0", bus.pass_start); end
    n_cmp++; if (bus.layer_done !== 1'b0) begin n_err++; $display("FAIL rst_layer_done got=%0b exp=0", bus.layer_done); end
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done got=%0b exp=0", bus.frame_done); end
    n_cmp++; if (bus.last_loop !== 1'b0) begin n_err++; $display("FAIL rst_last_loop got=%0b exp=0", bus.last_loop); end
    prev_state = 4'd0;
    seq_q.push_back(4'd0);
    mon_en = 1'b1;
    reset = 1'b1;
    tick();
    bus.start = 1'b0;
    n_cmp++; if (bus.state !== 4'd1) begin n_err++; $display("FAIL start_state got=%0d exp=1", bus.state); end
    n_cmp++; if (bus.layer_done !== 1'b0) begin n_err++; $display("FAIL start_layer_done got=%0b exp=0", bus.layer_done); end
    tick();
    n_cmp++; if (bus.state !== 4'd1) begin n_err++; $display("FAIL load_hold got=%0d exp=1", bus.state); end
  endtask

  task automatic test_conv1_1();
    int ps_cnt;
    aux_pulse();
    n_cmp++; if (bus.state !== 4'd2) begin n_err++; $display("FAIL c11_enter_state got=%0d exp=2", bus.state); end
    n_cmp++; if (bus.layer_done !== 1'b1) begin n_err++; $display("FAIL c11_enter_layer_done got=%0b exp=1", bus.layer_done); end
    ps_cnt = (bus.pass_start === 1'b1) ? 1 : 0;
    for (int f = 0; f < 6; f++) begin
      n_cmp++; if (bus.current_filter !== 5'(f)) begin n_err++; $display("FAIL c11_filter got=%0d exp=%0d", bus.current_filter, f); end
      n_cmp++; if (bus.current_loop !== 3'd0) begin n_err++; $display("FAIL c11_loop got=%0d exp=0", bus.current_loop); end
      n_cmp++; if (bus.last_loop !== 1'b1) begin n_err++; $display("FAIL c11_last_loop got=%0b exp=1", bus.last_loop); end
      run_passes(1, 6723);
      if (f < 5) begin
        if (bus.pass_start === 1'b1) ps_cnt++;
        n_cmp++; if (bus.state !== 4'd2) begin n_err++; $display("FAIL c11_stay got=%0d exp=2", bus.state); end
      end
    end
    n_cmp++; if (ps_cnt !== 6) begin n_err++; $display("FAIL c11_pass_starts got=%0d exp=6", ps_cnt); end
    n_cmp++; if (bus.state !== 4'd3) begin n_err++; $display("FAIL c11_exit_state got=%0d exp=3", bus.state); end
    n_cmp++; if (bus.layer_done !== 1'b1) begin n_err++; $display("FAIL c11_exit_layer_done got=%0b exp=1", bus.layer_done); end
    n_cmp++; if (bus.pass_start !== 1'b1) begin n_err++; $display("FAIL c12_enter_pass_start got=%0b exp=1", bus.pass_start); end
    n_cmp++; if (bus.current_filter !== 5'd0) begin n_err++; $display("FAIL c12_enter_filter got=%0d exp=0", bus.current_filter); end
  endtask

  task automatic test_distractors();
    bus.addr_valid = 1'b0; bus.Out_Address = 13'd6399; tick();
    bus.addr_valid = 1'b1; bus.Out_Address = 13'd6398; tick();
    bus.Out_Address = 13'd6400; tick();
    bus.addr_valid = 1'b0; bus.aux_done = 1'b1; tick();
    bus.aux_done = 1'b0;
    n_cmp++; if (bus.state !== 4'd3) begin n_err++; $display("FAIL dis_state got=%0d exp=3", bus.state); end
    n_cmp++; if (bus.current_loop !== 3'd0) begin n_err++; $display("FAIL dis_loop got=%0d exp=0", bus.current_loop); end
    n_cmp++; if (bus.current_filter !== 5'd0) begin n_err++; $display("FAIL dis_filter got=%0d exp=0", bus.current_filter); end
    n_cmp++; if (bus.pass_start !== 1'b0) begin n_err++; $display("FAIL dis_pass_start got=%0b exp=0", bus.pass_start); end
    n_cmp++; if (bus.layer_done !== 1'b0) begin n_err++; $display("FAIL dis_layer_done got=%0b exp=0", bus.layer_done); end
    run_passes(1, 6399);
    n_cmp++; if (bus.current_loop !== 3'd1) begin n_err++; $display("FAIL c12_loop1 got=%0d exp=1", bus.current_loop); end
    n_cmp++; if (bus.pass_start !== 1'b1) begin n_err++; $display("FAIL c12_pass_start got=%0b exp=1", bus.pass_start); end
    n_cmp++; if (bus.last_loop !== 1'b1) begin n_err++; $display("FAIL c12_last_loop got=%0b exp=1", bus.last_loop); end
    run_passes(11, 6399);
    n_cmp++; if (bus.state !== 4'd4) begin n_err++; $display("FAIL c12_exit_state got=%0d exp=4", bus.state); end
    n_cmp++; if (bus.layer_done !== 1'b1) begin n_err++; $display("FAIL c12_exit_layer_done got=%0b exp=1", bus.layer_done); end
    n_cmp++; if (bus.pass_start !== 1'b0) begin n_err++; $display("FAIL pool1_pass_start got=%0b exp=0", bus.pass_start); end
    n_cmp++; if (bus.last_loop !== 1'b0) begin n_err++; $display("FAIL pool1_last_loop got=%0b exp=0", bus.last_loop); end
    bus.addr_valid = 1'b1; bus.Out_Address = 13'd6399; tick();
    bus.addr_valid = 1'b0;
    n_cmp++; if (bus.current_loop !== 3'd0) begin n_err++; $display("FAIL pool1_addr_ignored got=%0d exp=0", bus.current_loop); end
  endtask

  task automatic test_start_ignored();
    aux_pulse();
    n_cmp++; if (bus.state !== 4'd5) begin n_err++; $display("FAIL c21_enter_state got=%0d exp=5", bus.state); end
    n_cmp++; if (bus.pass_start !== 1'b1) begin n_err++; $display("FAIL c21_enter_pass_start got=%0b exp=1", bus.pass_start); end
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    n_cmp++; if (bus.state !== 4'd5) begin n_err++; $display("FAIL c21_start_ignored got=%0d exp=5", bus.state); end
    run_passes(31, 1443);
    n_cmp++; if (bus.current_filter !== 5'd15) begin n_err++; $display("FAIL c21_filter got=%0d exp=15", bus.current_filter); end
    n_cmp++; if (bus.current_loop !== 3'd1) begin n_err++; $display("FAIL c21_loop got=%0d exp=1", bus.current_loop); end
    run_passes(1, 1443);
    n_cmp++; if (bus.state !== 4'd6) begin n_err++; $display("FAIL c21_exit_state got=%0d exp=6", bus.state); end
    n_cmp++; if (bus.layer_done !== 1'b1) begin n_err++; $display("FAIL c21_exit_layer_done got=%0b exp=1", bus.layer_done); end
  endtask

  task automatic test_conv2_2();
    for (int i = 0; i < 64; i++) begin
      n_cmp++; if (bus.current_loop !== 3'(i % 4)) begin n_err++; $display("FAIL c22_loop pass=%0d got=%0d exp=%0d", i, bus.current_loop, i % 4); end
      n_cmp++; if (bus.current_filter !== 5'(i / 4)) begin n_err++; $display("FAIL c22_filter pass=%0d got=%0d exp=%0d", i, bus.current_filter, i / 4); end
      n_cmp++; if (bus.last_loop !== ((i % 4) == 3)) begin n_err++; $display("FAIL c22_last_loop pass=%0d got=%0b exp=%0b", i, bus.last_loop, (i % 4) == 3); end
      run_passes(1, 1295);
    end
    n_cmp++; if (bus.state !== 4'd7) begin n_err++; $display("FAIL c22_exit_state got=%0d exp=7", bus.state); end
    n_cmp++; if (bus.layer_done !== 1'b1) begin n_err++; $display("FAIL c22_exit_layer_done got=%0b exp=1", bus.layer_done); end
    n_cmp++; if (bus.pass_start !== 1'b0) begin n_err++; $display("FAIL pool2_pass_start got=%0b exp=0", bus.pass_start); end
  endtask

  task automatic test_back_to_back();
    aux_pulse();
    n_cmp++; if (bus.state !== 4'd8) begin n_err++; $display("FAIL c31_enter_state got=%0d exp=8", bus.state); end
    run_passes(64, 255);
    n_cmp++; if (bus.state !== 4'd9) begin n_err++; $display("FAIL c31_exit_state got=%0d exp=9", bus.state); end
    n_cmp++; if (bus.pass_start !== 1'b1) begin n_err++; $display("FAIL c32_enter_pass_start got=%0b exp=1", bus.pass_start); end
    run_passes(63, 195);
    n_cmp++; if (bus.state !== 4'd9) begin n_err++; $display("FAIL c32_not_done got=%0d exp=9", bus.state); end
    run_passes(1, 195);
    n_cmp++; if (bus.state !== 4'd10) begin n_err++; $display("FAIL c32_exit_state got=%0d exp=10", bus.state); end
    aux_pulse();
    n_cmp++; if (bus.state !== 4'd11) begin n_err++; $display("FAIL fc_enter_state got=%0d exp=11", bus.state); end
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL fc_enter_frame_done got=%0b exp=0", bus.frame_done); end
    aux_pulse();
    n_cmp++; if (bus.state !== 4'd0) begin n_err++; $display("FAIL frame_end_state got=%0d exp=0", bus.state); end
    n_cmp++; if (bus.frame_done !== 1'b1) begin n_err++; $display("FAIL frame_done got=%0b exp=1", bus.frame_done); end
    n_cmp++; if (bus.layer_done !== 1'b1) begin n_err++; $display("FAIL frame_end_layer_done got=%0b exp=1", bus.layer_done); end
    tick();
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL frame_done_width got=%0b exp=0", bus.frame_done); end
    mon_en = 1'b0;
    n_cmp++; if (n_layer_pulses !== 11) begin n_err++; $display("FAIL layer_done_count got=%0d exp=11", n_layer_pulses); end
    n_cmp++; if (n_frame_pulses !== 1) begin n_err++; $display("FAIL frame_done_count got=%0d exp=1", n_frame_pulses); end
    n_cmp++; if (seq_q.size() !== 13) begin n_err++; $display("FAIL state_seq_len got=%0d exp=13", seq_q.size()); end
    for (int i = 0; i < seq_q.size() && i < 13; i++) begin
      n_cmp++; if (seq_q[i] !== 4'((i == 12) ? 0 : i)) begin n_err++; $display("FAIL state_seq idx=%0d got=%0d exp=%0d", i, seq_q[i], (i == 12) ? 0 : i); end
    end
  endtask

  task automatic test_mid_reset();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    aux_pulse();
    run_passes(6, 6723);
    run_passes(12, 6399);
    aux_pulse();
    run_passes(32, 1443);
    run_passes(64, 1295);
    aux_pulse();
    run_passes(30, 255);
    n_cmp++; if (bus.state !== 4'd8) begin n_err++; $display("FAIL mid_pre_state got=%0d exp=8", bus.state); end
    n_cmp++; if (bus.current_filter !== 5'd7) begin n_err++; $display("FAIL mid_pre_filter got=%0d exp=7", bus.current_filter); end
    n_cmp++; if (bus.current_loop !== 3'd2) begin n_err++; $display("FAIL mid_pre_loop got=%0d exp=2", bus.current_loop); end
    reset = 1'b0;
    bus.addr_valid = 1'b1; bus.Out_Address = 13'd255;
    tick();
    bus.addr_valid = 1'b0;
    n_cmp++; if (bus.state !== 4'd0) begin n_err++; $display("FAIL mid_state got=%0d exp=0", bus.state); end
    n_cmp++; if (bus.current_loop !== 3'd0) begin n_err++; $display("FAIL mid_loop got=%0d exp=0", bus.current_loop); end
    n_cmp++; if (bus.current_filter !== 5'd0) begin n_err++; $display("FAIL mid_filter got=%0d exp=0", bus.current_filter); end
    n_cmp++; if (bus.layer_done !== 1'b0) begin n_err++; $display("FAIL mid_layer_done got=%0b exp=0", bus.layer_done); end
    n_cmp++; if (bus.pass_start !== 1'b0) begin n_err++; $display("FAIL mid_pass_start got=%0b exp=0", bus.pass_start); end
    n_cmp++; if (bus.last_loop !== 1'b0) begin n_err++; $display("FAIL mid_last_loop got=%0b exp=0", bus.last_loop); end
    reset = 1'b1;
    tick();
    n_cmp++; if (bus.state !== 4'd0) begin n_err++; $display("FAIL post_reset_state got=%0d exp=0", bus.state); end
    n_cmp++; if (bus.layer_done !== 1'b0) begin n_err++; $display("FAIL post_reset_layer_done got=%0b exp=0", bus.layer_done); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_layer_pulses = 0;
    n_frame_pulses = 0;
    mon_en = 1'b0;
    prev_state = 4'd0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.aux_done = 1'b0;
    bus.addr_valid = 1'b0;
    bus.Out_Address = '0;
    test_reset();
    test_conv1_1();
    test_distractors();
    test_start_ignored();
    test_conv2_2();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Top-level layer scheduler for the human-on-railway CNN accelerator. It owns the global `state` bus that selects the active layer (load, CONV1_1…CONV3_2, pooling, FC) and counts input-channel loops and output filters for each convolution layer. It advances on end-of-map detection from the convolution output address stream and on done strobes from the non-convolution engines. It drives `Conv_Control`, the pooling engines and the weight loader, and replaces the free-running stimulus used in bring-up.

## Interface
Parameters:
- `STATE_DATAWIDTH`, 4, width of `state`
- `ADDRESS_DATAWIDTH`, 13, width of `Out_Address`
- `LOOP_DATAWIDTH`, 3, width of `current_loop`
- `FILTER_DATAWIDTH`, 5, width of `current_filter`
- `CONV1_1_OUTPUT_SIZE`…`CONV3_2_OUTPUT_SIZE`, 82/80/38/36/16/14, output map edge per conv layer
- `CONV1_1_LOOPS`…`CONV3_2_LOOPS`, 1/2/2/4/4/4, input-channel passes per filter (channels / 4 SA units)
- `CONV1_FILTERS`, `CONV2_FILTERS`, `CONV3_FILTERS`, 6/16/16, filters per block (both convs of a block)

Ports:
- `clk` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-low
- `start` in 1: frame start request, sampled in IDLE only
- `aux_done` in 1: one-cycle done from loader/pool/FC engine of the current non-conv state
- `addr_valid` in 1: `Out_Address` carries a valid write address this cycle
- `Out_Address` in `ADDRESS_DATAWIDTH`: conv output write address
- `state` out `STATE_DATAWIDTH`: active layer code
- `current_loop` out `LOOP_DATAWIDTH`: input-channel pass index
- `current_filter` out `FILTER_DATAWIDTH`: output filter index
- `last_loop` out 1: current pass is the final loop of the current filter
- `pass_start` out 1: one-cycle kick at the start of every conv pass
- `layer_done` out 1: one-cycle pulse when any layer completes
- `frame_done` out 1: one-cycle pulse on completion of FC

## Operation
- State codes: 0 IDLE, 1 LOAD, 2 CONV1_1, 3 CONV1_2, 4 POOL1, 5 CONV2_1, 6 CONV2_2, 7 POOL2, 8 CONV3_1, 9 CONV3_2, 10 POOL3, 11 FC. Codes 12–15 are illegal and return to IDLE on the next edge.
- IDLE→LOAD on `start`. `start` is ignored in every other state.
- Non-conv states (1, 4, 7, 10, 11) advance to code+1 on `aux_done`. FC returns to IDLE and pulses `frame_done`.
- Conv states: `LAST` = SIZE·SIZE−1, computed at elaboration (6723, 6399, 1443, 1295, 255, 195). Pass end = `addr_valid` && `Out_Address` == `LAST`.
- Each pass end increments `current_loop`. At `LOOPS`−1, `current_loop` wraps to 0 and `current_filter` increments.
- At the last loop of the last filter, both counters clear and `state` advances.
- Counters clear on every state change.
- `last_loop` is combinational: conv state && `current_loop` == `LOOPS`−1. It is 0 in non-conv states; for CONV1_1 it is 1 for every pass.
- Addresses other than `LAST`, and `addr_valid`=0, are ignored. `addr_valid` is ignored in non-conv states. `aux_done` is ignored in conv states and in IDLE.

## Timing
- All outputs are registered except `last_loop`.
- Reset values: `state`=0, `current_loop`=0, `current_filter`=0, `pass_start`=0, `layer_done`=0, `frame_done`=0. `last_loop` resets to 0 via `state`=0.
- Reset low mid-layer: all registers return to reset values at the next edge; no done pulses are issued.
- Pass end sampled at edge N: counters/`state` update at edge N, visible in cycle N+1.
- `pass_start` is high in cycle N+1 if the next cycle is the first of a conv pass. This covers entry into a conv state and every non-final pass end.
- `layer_done` is high in the first cycle of the next state, for both conv and non-conv completions. `frame_done` coincides with `layer_done` on the FC→IDLE transition.
- Back-to-back pass ends on consecutive cycles are each counted; no lost events.
- Total passes per conv layer = LOOPS·FILTERS: 6, 12, 32, 64, 64, 64.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `start`=1 → all outputs 0, `state`=0. Release → `state`=1 one cycle after `start` is sampled.
- CONV1_1: `aux_done` in LOAD, then 6 pass ends at `Out_Address`=6723 → `last_loop`=1 throughout; `current_filter` steps 0→5; 6 `pass_start` pulses; `state`=3 with `layer_done` after the 6th.
- CONV2_2: 64 pass ends at 1295 → `current_loop` cycles 0..3; `last_loop` high only at loop 3; `current_filter` reaches 15; then `state`=7.
- Distractors in CONV1_2: `Out_Address`=6399 with `addr_valid`=0, plus `Out_Address`=6398/6400 with `addr_valid`=1 → counters unchanged. `aux_done` in a conv state → no change.
- Reset mid-CONV3_1 at filter 7, loop 2 → next cycle `state`=0, counters 0, no `layer_done`.
- Full frame with back-to-back pass ends → `state` sequence 0,1,2…11,0. Exactly 11 `layer_done` pulses and one `frame_done`. A `start` raised during CONV2_1 is ignored.
